static_control_loader: RTL and testbench

//  Sequences static-control configuration into the chip's serial scan chain. A host

---
 rtl/static_control_loader.sv | 129 ++++++++++++
 tb/tb_static_control_loader.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/static_control_loader.sv
// Static-control scan loader: shifts a captured config word MSB-first on
// sclk/sdata, strobes slatch to commit it, and mirrors the result on shadow.
module static_control_loader #(
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             load_trigger,
  input  logic             abort,
  output logic             sclk,
  output logic             sdata,
  output logic             slatch,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [WIDTH-1:0] shadow
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int IW = $clog2(WIDTH);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SHIFT_LO = 3'd1;
  localparam logic [2:0] SHIFT_HI = 3'd2;
  localparam logic [2:0] LATCH    = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MSB  = IW'(WIDTH - 1);

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             ovr_q, ovr_d;
  logic             tick;
  logic             timed;
  logic             shifting;

  assign timed    = (state_q == SHIFT_LO) ||
                    (state_q == SHIFT_HI) ||
                    (state_q == LATCH);
  assign shifting = (state_q == SHIFT_LO) ||
                    (state_q == SHIFT_HI);
  assign tick     = (cnt_q == CNT_LAST);

  // Pins decode straight from the state register so abort/reset clear them
  assign sclk    = (state_q == SHIFT_HI);
  assign sdata   = shifting & shift_q[idx_q];
  assign slatch  = (state_q == LATCH);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign overrun = ovr_q;
  assign shadow  = shadow_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    idx_d    = idx_q;
    shift_d  = shift_q;
    shadow_d = shadow_q;
    ovr_d    = ovr_q;
    if (timed && !tick) begin
      cnt_d = cnt_q + CW'(1);
    end
    case (state_q)
      IDLE: begin
        if (load_trigger) begin
          shift_d = cfg_data;
          idx_d   = IDX_MSB;
          ovr_d   = 1'b0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (tick) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (tick) begin
          if (idx_q == '0) begin
            state_d = LATCH;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (tick) begin
          shadow_d = shift_q;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (busy && load_trigger) begin
      ovr_d = 1'b1;
    end
    // A commit already reported in DONE is allowed to finish
    if (abort && timed) begin
      state_d  = IDLE;
      cnt_d    = '0;
      shadow_d = shadow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      shadow_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      shadow_q <= shadow_d;
      ovr_q    <= ovr_d;
    end
  end

endmodule

// File: tb/tb_static_control_loader.sv
// Bench for static_control_loader: WIDTH=8 at CLK_DIV=2 and CLK_DIV=1,
// with a behavioural chip scan-chain model on the first instance.
module tb_static_control_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a_cfg = '0;
  logic       a_trig = 1'b0, a_abort = 1'b0;
  logic       a_sclk, a_sdata, a_slatch, a_busy, a_done, a_ovr;
  logic [7:0] a_shadow;

  logic [7:0] b_cfg = '0;
  logic       b_trig = 1'b0, b_abort = 1'b0;
  logic       b_sclk, b_sdata, b_slatch, b_busy, b_done, b_ovr;
  logic [7:0] b_shadow;

  static_control_loader #(.WIDTH(8), .CLK_DIV(2)) u_a (
    .clk(clk), .rst_n(rst_n), .cfg_data(a_cfg),
    .load_trigger(a_trig), .abort(a_abort),
    .sclk(a_sclk), .sdata(a_sdata), .slatch(a_slatch),
    .busy(a_busy), .done(a_done), .overrun(a_ovr),
    .shadow(a_shadow)
  );

  static_control_loader #(.WIDTH(8), .CLK_DIV(1)) u_b (
    .clk(clk), .rst_n(rst_n), .cfg_data(b_cfg),
    .load_trigger(b_trig), .abort(b_abort),
    .sclk(b_sclk), .sdata(b_sdata), .slatch(b_slatch),
    .busy(b_busy), .done(b_done), .overrun(b_ovr),
    .shadow(b_shadow)
  );

  // Chip-side scan chain: shift on sclk rise, commit on slatch rise
  logic [7:0] chip_sr = '0;
  logic [7:0] chip_cfg = '0;
  int         latch_evt = 0;
  always @(posedge a_sclk) chip_sr <= {chip_sr[6:0], a_sdata};
  always @(posedge a_slatch) begin
    chip_cfg  <= chip_sr;
    latch_evt <= latch_evt + 1;
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(
    input  logic [7:0] w,
    input  int         trig_at,
    input  logic [7:0] w2,
    input  int         abort_at,
    output int         nbusy,
    output int         ndone,
    output int         done_at,
    output int         nlatch,
    output int         viol,
    output bit         tmo
  );
    int k;
    logic psclk, psdata;
    nbusy = 0; ndone = 0; done_at = -1;
    nlatch = 0; viol = 0; tmo = 1'b0;
    a_cfg = w; a_trig = 1'b1;
    step();
    a_trig = 1'b0;
    k = 1; psclk = 1'b0; psdata = a_sdata;
    while (a_busy && !tmo) begin
      nbusy++;
      if (a_done) begin ndone++; done_at = k; end
      if (a_slatch) nlatch++;
      if (psclk && a_sclk && psdata !== a_sdata) viol++;
      psclk = a_sclk; psdata = a_sdata;
      a_trig = (k == trig_at);
      if (k == trig_at) a_cfg = w2;
      a_abort = (k == abort_at);
      step();
      k++;
      if (k > 500) tmo = 1'b1;
    end
    a_trig = 1'b0;
    a_abort = 1'b0;
  endtask

  task automatic load_b(
    input  logic [7:0] w,
    output int         nbusy,
    output int         done_at,
    output int         rises,
    output int         bad_period,
    output bit         tmo
  );
    int k, last;
    logic psclk;
    nbusy = 0; done_at = -1; rises = 0;
    bad_period = 0; tmo = 1'b0; last = -1;
    b_cfg = w; b_trig = 1'b1;
    step();
    b_trig = 1'b0;
    k = 1; psclk = 1'b0;
    while (b_busy && !tmo) begin
      nbusy++;
      if (b_done) done_at = k;
      if (!psclk && b_sclk) begin
        rises++;
        if (last > 0 && k - last != 2) bad_period++;
        last = k;
      end
      psclk = b_sclk;
      step();
      k++;
      if (k > 500) tmo = 1'b1;
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({a_sclk, a_sdata, a_slatch, a_busy, a_done, a_ovr} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_pins got=%b want=000000",
        {a_sclk, a_sdata, a_slatch, a_busy, a_done, a_ovr});
    end
    tests_run++;
    if (a_shadow !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_shadow got=%h want=00", a_shadow);
    end
    #8 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int nb, nd, da, nl, vi, le;
    bit to;
    le = latch_evt;
    load_a(8'hA5, -1, 8'h00, -1, nb, nd, da, nl, vi, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL basic_timeout"); end
    tests_run++;
    if (chip_cfg !== 8'hA5) begin
      tests_failed++;
      $display("FAIL basic_bits got=%h want=a5", chip_cfg);
    end
    tests_run++;
    if (nl !== 2) begin
      tests_failed++;
      $display("FAIL basic_latch_cycles got=%0d want=2", nl);
    end
    tests_run++;
    if (nb !== 35) begin
      tests_failed++;
      $display("FAIL basic_busy_cycles got=%0d want=35", nb);
    end
    tests_run++;
    if (nd !== 1 || da !== 35) begin
      tests_failed++;
      $display("FAIL basic_done got=%0d@%0d want=1@35", nd, da);
    end
    tests_run++;
    if (vi !== 0) begin
      tests_failed++;
      $display("FAIL basic_sdata_hi_change got=%0d want=0", vi);
    end
    tests_run++;
    if (a_shadow !== 8'hA5) begin
      tests_failed++;
      $display("FAIL basic_shadow got=%h want=a5", a_shadow);
    end
    tests_run++;
    if (latch_evt - le !== 1) begin
      tests_failed++;
      $display("FAIL basic_latch_events got=%0d want=1", latch_evt - le);
    end
  endtask

  task automatic test_overrun();
    int nb, nd, da, nl, vi;
    bit to;
    load_a(8'hA5, 5, 8'hFF, -1, nb, nd, da, nl, vi, to);
    tests_run++;
    if (chip_cfg !== 8'hA5 || a_shadow !== 8'hA5) begin
      tests_failed++;
      $display("FAIL ovr_bits got=%h/%h want=a5/a5", chip_cfg, a_shadow);
    end
    tests_run++;
    if (nb !== 35 || nd !== 1) begin
      tests_failed++;
      $display("FAIL ovr_no_restart got=%0d/%0d want=35/1", nb, nd);
    end
    tests_run++;
    if (a_ovr !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_set got=%b want=1", a_ovr);
    end
    load_a(8'hA5, -1, 8'h00, -1, nb, nd, da, nl, vi, to);
    tests_run++;
    if (a_ovr !== 1'b0 || nb !== 35) begin
      tests_failed++;
      $display("FAIL ovr_clear got=%b/%0d want=0/35", a_ovr, nb);
    end
  endtask

  task automatic test_abort();
    int nb, nd, da, nl, vi, le;
    bit to;
    le = latch_evt;
    load_a(8'h3C, -1, 8'h00, 13, nb, nd, da, nl, vi, to);
    tests_run++;
    if (nb !== 13) begin
      tests_failed++;
      $display("FAIL abort_busy_cycles got=%0d want=13", nb);
    end
    tests_run++;
    if ({a_sclk, a_sdata, a_slatch, a_busy} !== 4'b0) begin
      tests_failed++;
      $display("FAIL abort_pins got=%b want=0000",
        {a_sclk, a_sdata, a_slatch, a_busy});
    end
    tests_run++;
    if (nd !== 0 || nl !== 0 || latch_evt !== le) begin
      tests_failed++;
      $display("FAIL abort_no_commit got=%0d/%0d/%0d want=0/0/0",
        nd, nl, latch_evt - le);
    end
    tests_run++;
    if (a_shadow !== 8'hA5 || chip_cfg !== 8'hA5) begin
      tests_failed++;
      $display("FAIL abort_shadow got=%h/%h want=a5/a5", a_shadow, chip_cfg);
    end
  endtask

  task automatic test_async_reset();
    int le;
    bit saw_latch;
    le = latch_evt;
    a_cfg = 8'h3C; a_trig = 1'b1;
    step();
    a_trig = 1'b0;
    step();
    step();
    tests_run++;
    if (a_sclk !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_in_hi got=%b want=1", a_sclk);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({a_sclk, a_sdata, a_slatch, a_busy, a_done, a_ovr} !== 6'b0
        || a_shadow !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_async got=%b/%h want=000000/00",
        {a_sclk, a_sdata, a_slatch, a_busy, a_done, a_ovr}, a_shadow);
    end
    #4 rst_n = 1'b1;
    saw_latch = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (a_slatch || a_busy) saw_latch = 1'b1;
    end
    tests_run++;
    if (saw_latch || latch_evt !== le) begin
      tests_failed++;
      $display("FAIL rst_no_latch got=%b/%0d want=0/0",
        saw_latch, latch_evt - le);
    end
  endtask

  task automatic test_back_to_back();
    int nb, da, ri, bp;
    bit to;
    load_b(8'h5A, nb, da, ri, bp, to);
    tests_run++;
    if (to || nb !== 18 || da !== 18) begin
      tests_failed++;
      $display("FAIL b2b_first got=%0d@%0d want=18@18", nb, da);
    end
    tests_run++;
    if (b_shadow !== 8'h5A) begin
      tests_failed++;
      $display("FAIL b2b_first_shadow got=%h want=5a", b_shadow);
    end
    load_b(8'h96, nb, da, ri, bp, to);
    tests_run++;
    if (to || nb !== 18 || da !== 18) begin
      tests_failed++;
      $display("FAIL b2b_second got=%0d@%0d want=18@18", nb, da);
    end
    tests_run++;
    if (ri !== 8 || bp !== 0) begin
      tests_failed++;
      $display("FAIL b2b_sclk_period got=%0d rises %0d bad want=8/0", ri, bp);
    end
    tests_run++;
    if (b_ovr !== 1'b0 || b_shadow !== 8'h96) begin
      tests_failed++;
      $display("FAIL b2b_result got=%b/%h want=0/96", b_ovr, b_shadow);
    end
  endtask

  task automatic test_random();
    int nb, nd, da, nl, vi;
    bit to;
    logic [7:0] w;
    for (int i = 0; i < 100; i++) begin
      w = 8'($urandom_range(0, 255));
      load_a(w, -1, 8'h00, -1, nb, nd, da, nl, vi, to);
      tests_run++;
      if (to || chip_cfg !== w || a_shadow !== w) begin
        tests_failed++;
        $display("FAIL rand_%0d got chip=%h shadow=%h want=%h",
          i, chip_cfg, a_shadow, w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
